// File: rtl/arbiter_rr_n.sv
// Round-robin arbiter for N_REQ requesters. The grant, its index and busy are all
// registered. An owner keeps the grant until release, or is preempted after MAX_HOLD cycles.
module arbiter_rr_n #(
  parameter int N_REQ    = 3,
  parameter int MAX_HOLD = 8,
  localparam int IDW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   grant_id,
  output logic             busy
);

  // state   | meaning
  // S_IDLE  | no owner, grant all-zero
  // S_OWNED | one client holds the resource, grant one-hot
  typedef enum logic {S_IDLE, S_OWNED} state_t;

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [HW-1:0]   hold_cnt;

  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] pick_onehot;
  logic [IDW-1:0]   pick_id;
  logic [IDW-1:0]   pick_ptr;
  logic             pick_found;
  logic             owner_req;
  logic             hold_done;
  logic             do_grant;
  logic             go_idle;

  // ptr always equals owner+1 while owned, so one search from ptr covers both
  // the idle pick and the handover; the owner's bit is masked from candidates.
  always_comb begin
    int hi;
    int lo;
    int pick;
    hi = N_REQ;
    lo = N_REQ;
    cand = req & ~grant;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        lo = i;
        if (i >= int'(ptr)) hi = i;
      end
    end
    pick        = (hi < N_REQ) ? hi : lo;
    pick_found  = (pick < N_REQ);
    pick_id     = pick_found ? IDW'(pick) : '0;
    pick_ptr    = (pick_found && (pick + 1 < N_REQ)) ? IDW'(pick + 1) : '0;
    pick_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pick_onehot[i] = pick_found && (i == pick);
    end

    owner_req = |(req & grant);
    hold_done = (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX);
    do_grant  = 1'b0;
    go_idle   = 1'b0;
    case (state)
      S_IDLE:  do_grant = pick_found;
      S_OWNED: begin
        if (!owner_req) begin
          do_grant = pick_found;
          go_idle  = !pick_found;
        end else begin
          do_grant = hold_done && pick_found;
        end
      end
      default: go_idle = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else if (do_grant) begin
      state    <= S_OWNED;
      ptr      <= pick_ptr;
      hold_cnt <= (MAX_HOLD != 0) ? HW'(1) : '0;
      grant    <= pick_onehot;
      grant_id <= pick_id;
      busy     <= 1'b1;
    end else if (go_idle) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else if (state == S_OWNED && MAX_HOLD != 0 && !hold_done) begin
      hold_cnt <= hold_cnt + HW'(1);
    end
  end

endmodule

// File: tb/tb_arbiter_rr_n.sv
// Bench for arbiter_rr_n: runs a timed-tenure instance and a lock-mode instance on
// the same req. Both are checked every cycle against a queue-free owner/pointer model.
module tb_arbiter_rr_n;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] grant_a, grant_b;
  logic [1:0]   id_a, id_b;
  logic         busy_a, busy_b;

  int n_tests = 0;
  int n_fail  = 0;

  int m_owner[2];
  int m_ptr[2];
  int m_ten[2];
  int m_max[2];

  arbiter_rr_n #(.N_REQ(N), .MAX_HOLD(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(grant_a), .grant_id(id_a), .busy(busy_a)
  );

  arbiter_rr_n #(.N_REQ(N), .MAX_HOLD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(grant_b), .grant_id(id_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_ptr[k]   = 0;
      m_ten[k]   = 0;
    end
  endtask

  // Behavioural rules: idle picks from ptr; an owner is replaced on release or
  // once it has used its full tenure with others waiting.
  task automatic model_step(input int k);
    int w;
    bit rel;
    bit expired;
    w = -1;
    if (m_owner[k] < 0) begin
      for (int i = 0; i < N; i++) begin
        if (w < 0 && req[(m_ptr[k] + i) % N]) w = (m_ptr[k] + i) % N;
      end
      rel = 1'b0;
    end else begin
      rel     = !req[m_owner[k]];
      expired = (m_max[k] != 0) && (m_ten[k] >= m_max[k]);
      if (rel || expired) begin
        for (int i = 1; i < N; i++) begin
          if (w < 0 && req[(m_owner[k] + i) % N]) w = (m_owner[k] + i) % N;
        end
      end
    end
    if (w >= 0) begin
      m_owner[k] = w;
      m_ten[k]   = 1;
      m_ptr[k]   = (w + 1) % N;
    end else if (m_owner[k] >= 0) begin
      if (rel) m_owner[k] = -1;
      else     m_ten[k]++;
    end
  endtask

  task automatic check_outputs(input string tag);
    int eg, ei, eb;
    for (int k = 0; k < 2; k++) begin
      eg = (m_owner[k] < 0) ? 0 : (1 << m_owner[k]);
      ei = (m_owner[k] < 0) ? 0 : m_owner[k];
      eb = (m_owner[k] < 0) ? 0 : 1;
      if (k == 0) begin
        chk({tag, " grant_a"}, int'(grant_a), eg);
        chk({tag, " id_a"},    int'(id_a),    ei);
        chk({tag, " busy_a"},  int'(busy_a),  eb);
      end else begin
        chk({tag, " grant_b"}, int'(grant_b), eg);
        chk({tag, " id_b"},    int'(id_b),    ei);
        chk({tag, " busy_b"},  int'(busy_b),  eb);
      end
    end
  endtask

  task automatic cycle(input logic [N-1:0] r, input string tag);
    req = r;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_outputs(tag);
  endtask

  task automatic async_reset(input logic [N-1:0] r);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("reset");
    req = r;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    m_max[0] = 8;
    m_max[1] = 0;
    model_reset();
    #12;
    check_outputs("por");
    rst_n = 1'b1;

    // fair rotation (timed) and lock (untimed), then lock handover on release
    for (int c = 0; c < 26; c++) cycle(3'b111, "rotate");
    chk("rot_id_end", int'(id_a), 0);
    chk("lock_owner", int'(grant_b), 1);
    cycle(3'b110, "lock_release");
    chk("lock_next", int'(grant_b), 2);

    // mid-tenure reset with owner 2, restart with all requesting
    for (int c = 0; c < 3; c++) cycle(3'b100, "own2");
    chk("own2_grant", int'(grant_a), 4);
    async_reset(3'b111);
    cycle(3'b111, "post_reset");
    chk("post_reset_grant", int'(grant_a), 1);

    // lone requester never preempted
    for (int c = 0; c < 22; c++) cycle(3'b010, "lone");
    chk("lone_grant", int'(grant_a), 2);

    // release to idle, three idle cycles, re-request
    for (int c = 0; c < 4; c++) cycle(3'b000, "idle");
    cycle(3'b001, "rereq");
    chk("rereq_grant", int'(grant_a), 1);

    // wrap and skip
    cycle(3'b100, "to2");
    cycle(3'b100, "hold2");
    cycle(3'b001, "wrap");
    chk("wrap_grant", int'(grant_a), 1);
    cycle(3'b110, "skip");
    chk("skip_grant", int'(grant_a), 2);

    // random sticky requests with occasional async reset
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      end
      if ($urandom_range(0, 299) == 0) async_reset(r);
      cycle(r, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
